// File: rtl/wb_rr_arbiter.sv
// Two-master Wishbone arbiter in front of the OpenRAM Wishbone slave wrapper.
// Master 0 is the management SoC bus and master 1 is user-area logic. The
// arbiter grants round-robin on contention and holds the grant while the
// owner keeps cyc high. Each master transfer becomes a single-cycle slave
// strobe, so a slave that acks on every strobe cycle cannot double-ack.
// A timeout in WAIT returns err to the owner.
module wb_rr_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 15,
  parameter int unsigned CNT_WIDTH      = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,

  // Master 0 (management SoC)
  input  logic        m0_stb_i,
  input  logic        m0_cyc_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_dat_i,
  input  logic [31:0] m0_adr_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic [31:0] m0_dat_o,

  // Master 1 (user area)
  input  logic        m1_stb_i,
  input  logic        m1_cyc_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_dat_i,
  input  logic [31:0] m1_adr_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] m1_dat_o,

  // Slave side
  output logic        s_stb_o,
  output logic        s_cyc_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_dat_o,
  output logic [31:0] s_adr_o,
  input  logic        s_ack_i,
  input  logic [31:0] s_dat_i,

  // Status
  output logic        owner_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  state_e               state_q, state_d;
  logic                 owner_q, owner_d;
  // Set once a grant has been made since reset; until then the reset owner
  // value only biases round-robin and never locks the bus for master 1.
  logic                 granted_q, granted_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 s_stb_q, s_stb_d;
  logic                 s_cyc_q, s_cyc_d;

  logic req0, req1;
  logic own_cyc, own_stb;
  logic timeout_hit;
  logic ack_fire, err_fire;

  // Request decode and owner's bus view
  assign req0        = m0_cyc_i & m0_stb_i;
  assign req1        = m1_cyc_i & m1_stb_i;
  assign own_cyc     = owner_q ? m1_cyc_i : m0_cyc_i;
  assign own_stb     = owner_q ? m1_stb_i : m0_stb_i;
  assign timeout_hit = (cnt_q == CNT_LAST);

  // Ack is forwarded only in WAIT; ack beats both abort and timeout
  assign ack_fire = (state_q == ST_WAIT) & s_ack_i;
  assign err_fire = (state_q == ST_WAIT) & ~s_ack_i & own_cyc & timeout_hit;

  // Next-state, grant and timeout counter logic
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    granted_d = granted_q;
    cnt_d     = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (granted_q && own_cyc) begin
          // Burst lock: owner keeps the bus while cyc is high
          if (own_stb) begin
            state_d = ST_ISSUE;
          end
        end else if (req0 && !req1) begin
          owner_d = 1'b0;
          state_d = ST_ISSUE;
        end else if (req1 && !req0) begin
          owner_d = 1'b1;
          state_d = ST_ISSUE;
        end else if (req0 && req1) begin
          owner_d = ~owner_q;
          state_d = ST_ISSUE;
        end
        if (state_d == ST_ISSUE) begin
          granted_d = 1'b1;
        end
      end

      ST_ISSUE: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end

      ST_WAIT: begin
        if (s_ack_i) begin
          state_d = ST_IDLE;
        end else if (!own_cyc) begin
          state_d = ST_IDLE;
        end else if (timeout_hit) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    s_stb_d = (state_d == ST_ISSUE);
    s_cyc_d = (state_d == ST_ISSUE) || (state_d == ST_WAIT);
  end

  // State, grant, counter and registered slave strobes
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= ST_IDLE;
      owner_q   <= 1'b1;
      granted_q <= 1'b0;
      cnt_q     <= '0;
      s_stb_q   <= 1'b0;
      s_cyc_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      granted_q <= granted_d;
      cnt_q     <= cnt_d;
      s_stb_q   <= s_stb_d;
      s_cyc_q   <= s_cyc_d;
    end
  end

  // Slave request path follows the current owner
  assign s_stb_o = s_stb_q;
  assign s_cyc_o = s_cyc_q;
  assign s_we_o  = owner_q ? m1_we_i  : m0_we_i;
  assign s_sel_o = owner_q ? m1_sel_i : m0_sel_i;
  assign s_dat_o = owner_q ? m1_dat_i : m0_dat_i;
  assign s_adr_o = owner_q ? m1_adr_i : m0_adr_i;

  // Response path: data broadcast, ack/err steered to the owner only
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = ack_fire & ~owner_q;
  assign m1_ack_o = ack_fire &  owner_q;
  assign m0_err_o = err_fire & ~owner_q;
  assign m1_err_o = err_fire &  owner_q;

  assign owner_o = owner_q;
  assign busy_o  = s_cyc_q;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter with a hand-driven slave.
module tb_wb_rr_arbiter;

  logic        clk;
  logic        rst;
  logic        m0_stb, m0_cyc, m0_we;
  logic [3:0]  m0_sel;
  logic [31:0] m0_dat, m0_adr;
  logic        m0_ack, m0_err;
  logic [31:0] m0_rdat;
  logic        m1_stb, m1_cyc, m1_we;
  logic [3:0]  m1_sel;
  logic [31:0] m1_dat, m1_adr;
  logic        m1_ack, m1_err;
  logic [31:0] m1_rdat;
  logic        s_stb, s_cyc, s_we;
  logic [3:0]  s_sel;
  logic [31:0] s_wdat, s_adr;
  logic        s_ack;
  logic [31:0] s_rdat;
  logic        owner, busy;

  int n_checks;
  int n_fail;

  wb_rr_arbiter #(.TIMEOUT_CYCLES(15), .CNT_WIDTH(8)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .m0_stb_i (m0_stb),
    .m0_cyc_i (m0_cyc),
    .m0_we_i  (m0_we),
    .m0_sel_i (m0_sel),
    .m0_dat_i (m0_dat),
    .m0_adr_i (m0_adr),
    .m0_ack_o (m0_ack),
    .m0_err_o (m0_err),
    .m0_dat_o (m0_rdat),
    .m1_stb_i (m1_stb),
    .m1_cyc_i (m1_cyc),
    .m1_we_i  (m1_we),
    .m1_sel_i (m1_sel),
    .m1_dat_i (m1_dat),
    .m1_adr_i (m1_adr),
    .m1_ack_o (m1_ack),
    .m1_err_o (m1_err),
    .m1_dat_o (m1_rdat),
    .s_stb_o  (s_stb),
    .s_cyc_o  (s_cyc),
    .s_we_o   (s_we),
    .s_sel_o  (s_sel),
    .s_dat_o  (s_wdat),
    .s_adr_o  (s_adr),
    .s_ack_i  (s_ack),
    .s_dat_i  (s_rdat),
    .owner_o  (owner),
    .busy_o   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_master(input logic who);
    if (who) begin
      m1_cyc = 1'b0; m1_stb = 1'b0;
    end else begin
      m0_cyc = 1'b0; m0_stb = 1'b0;
    end
  endtask

  // From ISSUE: slave acks in the first WAIT cycle, ends back in IDLE
  task automatic complete(input string tag, input logic who, input logic drop);
    tick();
    s_ack = 1'b1;
    #1;
    chk_eq({tag, "_ack"},       who ? m1_ack : m0_ack, 32'd1);
    chk_eq({tag, "_other_ack"}, who ? m0_ack : m1_ack, 32'd0);
    if (drop) drop_master(who);
    tick();
    s_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    m0_stb = 1'b0; m0_cyc = 1'b0; m0_we = 1'b0; m0_sel = 4'hF;
    m0_dat = '0;   m0_adr = '0;
    m1_stb = 1'b0; m1_cyc = 1'b0; m1_we = 1'b0; m1_sel = 4'hF;
    m1_dat = '0;   m1_adr = '0;
    s_ack  = 1'b0; s_rdat = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // Reset values
    rst    = 1'b1;
    m0_stb = 1'b0; m0_cyc = 1'b0; m0_we = 1'b0; m0_sel = 4'hF;
    m0_dat = '0;   m0_adr = '0;
    m1_stb = 1'b0; m1_cyc = 1'b0; m1_we = 1'b0; m1_sel = 4'hF;
    m1_dat = '0;   m1_adr = '0;
    s_ack  = 1'b0; s_rdat = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_eq("rst_s_stb", s_stb, 32'd0);
    chk_eq("rst_s_cyc", s_cyc, 32'd0);
    chk_eq("rst_busy",  busy,  32'd0);
    chk_eq("rst_owner", owner, 32'd1);
    chk_eq("rst_m0_ack", m0_ack, 32'd0);

    // Single m0 read
    do_reset();
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b0; m0_adr = 32'h3000_0004;
    #1;
    chk_eq("t1_idle_stb", s_stb, 32'd0);
    tick();
    chk_eq("t1_issue_stb",   s_stb, 32'd1);
    chk_eq("t1_issue_cyc",   s_cyc, 32'd1);
    chk_eq("t1_issue_adr",   s_adr, 32'h3000_0004);
    chk_eq("t1_issue_owner", owner, 32'd0);
    chk_eq("t1_issue_busy",  busy,  32'd1);
    tick();
    s_ack = 1'b1; s_rdat = 32'hA5A5_0001;
    #1;
    chk_eq("t1_wait_stb", s_stb,   32'd0);
    chk_eq("t1_m0_ack",   m0_ack,  32'd1);
    chk_eq("t1_m0_dat",   m0_rdat, 32'hA5A5_0001);
    chk_eq("t1_m1_ack",   m1_ack,  32'd0);
    drop_master(1'b0);
    tick();
    s_ack = 1'b0;
    #1;
    chk_eq("t1_idle_ack",  m0_ack, 32'd0);
    chk_eq("t1_idle_busy", busy,   32'd0);

    // Contention after reset: m0 first, then m1; second round m1 first
    do_reset();
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1; m0_adr = 32'h0000_0100; m0_dat = 32'h1111_1111;
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1; m1_adr = 32'h0000_0200; m1_dat = 32'h2222_2222;
    m1_sel = 4'h3;
    tick();
    chk_eq("t2a_owner", owner,  32'd0);
    chk_eq("t2a_adr",   s_adr,  32'h0000_0100);
    chk_eq("t2a_dat",   s_wdat, 32'h1111_1111);
    chk_eq("t2a_we",    s_we,   32'd1);
    complete("t2a", 1'b0, 1'b1);
    #1;
    chk_eq("t2a_idle_busy", busy, 32'd0);
    tick();
    chk_eq("t2b_owner", owner, 32'd1);
    chk_eq("t2b_adr",   s_adr, 32'h0000_0200);
    chk_eq("t2b_sel",   s_sel, 32'h3);
    complete("t2b", 1'b1, 1'b1);
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h0000_0104;
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'h0000_0204;
    tick();
    chk_eq("t2c_owner", owner, 32'd1);
    chk_eq("t2c_adr",   s_adr, 32'h0000_0204);
    complete("t2c", 1'b1, 1'b1);
    tick();
    chk_eq("t2d_owner", owner, 32'd0);
    chk_eq("t2d_adr",   s_adr, 32'h0000_0104);
    complete("t2d", 1'b0, 1'b1);

    // m1 4-beat burst locks out m0
    do_reset();
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1; m1_adr = 32'h0000_0400; m1_dat = 32'h0000_00B0;
    tick();
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1; m0_adr = 32'h0000_0500;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk_eq("t3_issue_owner", owner, 32'd1);
      chk_eq("t3_issue_stb",   s_stb, 32'd1);
      chk_eq("t3_issue_adr",   s_adr, 32'h0000_0400 + 32'(4 * k));
      tick();
      s_ack = 1'b1;
      #1;
      chk_eq("t3_m1_ack", m1_ack, 32'd1);
      chk_eq("t3_m0_ack", m0_ack, 32'd0);
      if (k == 3) drop_master(1'b1);
      else m1_adr = 32'h0000_0400 + 32'(4 * (k + 1));
      tick();
      s_ack = 1'b0;
      #1;
      chk_eq("t3_idle_owner", owner, 32'd1);
      chk_eq("t3_idle_busy",  busy,  32'd0);
      tick();
    end
    #1;
    chk_eq("t3_m0_owner", owner, 32'd0);
    chk_eq("t3_m0_adr",   s_adr, 32'h0000_0500);
    complete("t3_m0", 1'b0, 1'b1);

    // Slave never acks: err after 15 WAIT cycles, then m1 served
    do_reset();
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b0; m0_adr = 32'h0000_0600;
    tick();
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk_eq("t4_m0_err", m0_err, (i == 15) ? 32'd1 : 32'd0);
      if (i == 15) begin
        chk_eq("t4_m0_ack_at_err", m0_ack, 32'd0);
        drop_master(1'b0);
      end
    end
    tick();
    chk_eq("t4_post_err",  m0_err, 32'd0);
    chk_eq("t4_post_busy", busy,   32'd0);
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'h0000_0610;
    tick();
    chk_eq("t4_m1_owner", owner, 32'd1);
    chk_eq("t4_m1_stb",   s_stb, 32'd1);
    complete("t4_m1", 1'b1, 1'b1);

    // Ack on the last timeout count: ack wins
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h0000_0620;
    tick();
    for (int i = 1; i <= 14; i++) tick();
    tick();
    s_ack = 1'b1; s_rdat = 32'h0BAD_F00D;
    #1;
    chk_eq("t5_m0_ack", m0_ack,  32'd1);
    chk_eq("t5_m0_err", m0_err,  32'd0);
    chk_eq("t5_m0_dat", m0_rdat, 32'h0BAD_F00D);
    drop_master(1'b0);
    tick();
    s_ack = 1'b0;

    // m0 aborts in WAIT, late ack is dropped, m1 issues next cycle
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h0000_0630;
    tick();
    tick();
    drop_master(1'b0);
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'h0000_0700;
    #1;
    chk_eq("t6_abort_ack", m0_ack, 32'd0);
    tick();
    s_ack = 1'b1;
    #1;
    chk_eq("t6_late_m0_ack", m0_ack, 32'd0);
    chk_eq("t6_late_m1_ack", m1_ack, 32'd0);
    tick();
    chk_eq("t6_m1_stb",       s_stb,  32'd1);
    chk_eq("t6_m1_owner",     owner,  32'd1);
    chk_eq("t6_issue_m1_ack", m1_ack, 32'd0);
    chk_eq("t6_m1_adr",       s_adr,  32'h0000_0700);
    s_ack = 1'b0;
    complete("t6_m1", 1'b1, 1'b1);

    // Reset in WAIT drops outputs immediately, m0 wins after release
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h0000_0800;
    tick();
    tick();
    s_ack = 1'b1;
    #1;
    chk_eq("t7_pre_ack", m0_ack, 32'd1);
    rst = 1'b1;
    #1;
    chk_eq("t7_rst_cyc",   s_cyc,  32'd0);
    chk_eq("t7_rst_busy",  busy,   32'd0);
    chk_eq("t7_rst_m0ack", m0_ack, 32'd0);
    chk_eq("t7_rst_m1ack", m1_ack, 32'd0);
    chk_eq("t7_rst_owner", owner,  32'd1);
    s_ack = 1'b0;
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'h0000_0900;
    #2;
    rst = 1'b0;
    tick();
    chk_eq("t7_m0_owner", owner, 32'd0);
    chk_eq("t7_m0_stb",   s_stb, 32'd1);
    chk_eq("t7_m0_adr",   s_adr, 32'h0000_0800);
    complete("t7_m0", 1'b0, 1'b1);
    tick();
    chk_eq("t7_m1_owner", owner, 32'd1);
    complete("t7_m1", 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
- Two-master Wishbone arbiter that sits directly upstream of the OpenRAM Wishbone slave wrapper.
- Master 0 is the Caravel management SoC bus; master 1 is user-area logic such as a DMA or accelerator.
- Grants one master at a time, using round-robin on contention, and holds the grant while the owner keeps cyc asserted.
- Converts each master transfer into a single-cycle slave strobe, so the slave's "ack every cycle stb is high" behaviour cannot produce duplicate acks. Adds a timeout that returns err.

Parameters:
- TIMEOUT_CYCLES, 15: cycles spent in WAIT without slave ack before err is returned. Legal range 1..255.
- CNT_WIDTH, 8: width of the timeout counter.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  asynchronous, active-high reset
- m0_stb_i, m0_cyc_i, m0_we_i  in  1 each  master 0 strobe, cycle, write enable
- m0_sel_i  in  4  master 0 byte select
- m0_dat_i  in  32  master 0 write data
- m0_adr_i  in  32  master 0 address
- m0_ack_o  out  1  master 0 ack
- m0_err_o  out  1  master 0 error (timeout)
- m0_dat_o  out  32  master 0 read data
- m1_*  same set as m0_*, for master 1
- s_stb_o, s_cyc_o, s_we_o  out  1 each  to slave
- s_sel_o  out  4  to slave
- s_dat_o  out  32  to slave
- s_adr_o  out  32  to slave
- s_ack_i  in  1  from slave
- s_dat_i  in  32  from slave
- owner_o  out  1  current/last grant: 0 = m0, 1 = m1
- busy_o  out  1  high in ISSUE or WAIT

Behaviour:
- Reset (async, wb_rst_i=1):
  - state = IDLE, owner = 1, so m0 wins the first contention.
  - counter = 0.
  - All ack/err/s_stb/s_cyc/busy outputs are 0.
- reqN = mN_cyc_i & mN_stb_i.
- State IDLE:
  - If the current owner's cyc is high and its stb is high, keep owner and go to ISSUE (burst lock).
  - Else if exactly one reqN, owner = N, go to ISSUE.
  - Else if both request, owner = the master NOT equal to the previous owner, go to ISSUE.
  - Else stay in IDLE.
  - If the owner's cyc is high but its stb is low, the lock persists and the other master waits.
- State ISSUE (exactly 1 cycle):
  - s_stb_o = s_cyc_o = 1.
  - Go to WAIT; counter = 0.
- State WAIT:
  - s_cyc_o = 1, s_stb_o = 0.
  - If s_ack_i: owner ack_o = 1 combinationally in that same cycle, then go to IDLE.
  - Else if the owner drops cyc (abort): go to IDLE; no ack or err.
  - Else if counter == TIMEOUT_CYCLES-1: owner err_o = 1 for that cycle, then go to IDLE.
  - Else counter += 1.
  - If ack and timeout occur in the same cycle, ack wins and err stays 0.
- Slave address/data/sel/we: combinational mux of the owner's inputs. Wishbone requires masters to hold these stable while stb is high.
- Read data: m0_dat_o = m1_dat_o = s_dat_i. Only the owner's ack qualifies it.
- Non-owner: ack_o and err_o are always 0. Its stb is ignored until it wins the grant.
- s_ack_i arriving in IDLE or ISSUE is ignored and never forwarded.
- Latency: master stb sampled at edge N → s_stb_o in cycle N+1 → slave ack in N+2 → master ack in N+2. Minimum 3 cycles per transfer.
- Reset mid-operation: outputs drop immediately (async); the in-flight transfer is lost; the first post-reset grant follows reset rules.

Test Plan:
- m0 read, adr 0x3000_0004, slave returns 0xA5A5_0001 one cycle after s_stb_o → s_stb_o high exactly 1 cycle; m0_ack_o 1 cycle with m0_dat_o = 0xA5A5_0001; m1_ack_o stays 0.
- m0 and m1 both request writes the same cycle after reset:
  - m0 is served first, m1 second.
  - Repeat with both requesting again → m1 is served first.
  - s_adr_o matches each owner's address during its ISSUE cycle.
- m1 holds cyc for a 4-write burst (stb re-asserted after each ack) while m0 requests continuously → all 4 m1 writes complete before m0's first ISSUE; owner_o = 1 throughout.
- Slave never acks, TIMEOUT_CYCLES = 15 → m0_err_o pulses once, 15 cycles after the ISSUE cycle; the state returns to IDLE; a later m1 request is served normally.
- Ack and timeout coincide (ack on the last count) → ack = 1, err = 0.
- m0 drops cyc in WAIT, then the slave acks late → m0_ack_o never asserts; the next m1 request issues on the following cycle.
- Assert wb_rst_i during WAIT → s_cyc_o, busy_o and all acks drop in the same cycle without waiting for a clock edge; after release, contention grants m0 first.
